// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the I/D memory arbiter.
//                Arbiter FSM states, port identifiers, the registered
//                memory-request bundle and the post-transaction gap length.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ARB_AW     = 16;
    localparam int ARB_DW     = 16;
    localparam int ARB_BE     = ARB_DW / 8;
    // Idle cycles inserted after every transaction (memory recovery cycle).
    localparam int GAP_CYCLES = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        GAP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_e;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ARB_BE-1:0] byte_enable;
        logic [ARB_AW-1:0] address;
        logic [ARB_DW-1:0] wdata;
    } mem_req_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pick
//  Description : Combinational winner select between the I and D requesters.
//                Optional feature macro: ARB_ROUND_ROBIN_EN
//                  defined   - on a tie, grant the port that did not win last
//                  undefined - fixed priority, D beats I
//  Ports       : i_i_req      in  I port has a pending request
//                i_d_req      in  D port has a pending request
//                i_last_grant in  port served by the previous transaction
//                o_valid      out at least one request pending
//                o_port       out winning port (meaningful when o_valid=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic      i_i_req,
    input  logic      i_d_req,
    input  arb_port_e i_last_grant,
    output logic      o_valid,
    output arb_port_e o_port
);

    assign o_valid = i_i_req | i_d_req;

    always_comb begin
        o_port = PORT_I;
        if (i_d_req && i_i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            // Tie: alternate away from whoever was served last.
            o_port = (i_last_grant == PORT_I) ? PORT_D : PORT_I;
`else
            o_port = PORT_D;
`endif
        end else if (i_d_req) begin
            o_port = PORT_D;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    // History is still supplied by the top but does not affect the pick.
    logic w_unused_last;
    assign w_unused_last = i_last_grant;
`endif

endmodule : arb_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one 16-bit byte-addressed memory between an
//                instruction-fetch port (I, read-only) and a data port (D).
//                One transaction at a time; the memory request is registered
//                and held stable until mem_resp, then one idle cycle follows.
//                Optional feature macro: ARB_ROUND_ROBIN_EN (see arb_pick).
//                AW/DW must match the package request-bundle widths.
//  Ports       : clk, rst_n                 clock, async active-low reset
//                i_read/i_address           I read request (held until i_resp)
//                i_resp/i_rdata             I done pulse and read data
//                d_read/d_write             D request (write wins if both)
//                d_byte_enable/d_address/d_wdata  D command fields
//                d_resp/d_rdata             D done pulse and returned word
//                mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata
//                                           registered memory command
//                mem_resp/mem_rdata         memory done pulse and data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
) (
    input  logic            clk,
    input  logic            rst_n,
    // I port
    input  logic            i_read,
    input  logic [AW-1:0]   i_address,
    output logic            i_resp,
    output logic [DW-1:0]   i_rdata,
    // D port
    input  logic            d_read,
    input  logic            d_write,
    input  logic [DW/8-1:0] d_byte_enable,
    input  logic [AW-1:0]   d_address,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_resp,
    output logic [DW-1:0]   d_rdata,
    // Memory side
    output logic            mem_read,
    output logic            mem_write,
    output logic [DW/8-1:0] mem_byte_enable,
    output logic [AW-1:0]   mem_address,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_resp,
    input  logic [DW-1:0]   mem_rdata
);

    arb_state_e r_state,    w_state_nxt;
    mem_req_t   r_req,      w_req_nxt;
    arb_port_e  r_last,     w_last_nxt;
    logic [1:0] r_gap_cnt,  w_gap_cnt_nxt;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;

    logic      w_grant_valid;
    arb_port_e w_grant_port;
    logic      w_i_resp;
    logic      w_d_resp;

    arb_pick u_pick (
        .i_i_req      (i_read),
        .i_d_req      (d_read | d_write),
        .i_last_grant (r_last),
        .o_valid      (w_grant_valid),
        .o_port       (w_grant_port)
    );

    // Response is gated by the owning BUSY state so a stray mem_resp in
    // IDLE/GAP never reaches either port.
    assign w_i_resp = (r_state == BUSY_I) && mem_resp;
    assign w_d_resp = (r_state == BUSY_D) && mem_resp;

    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_last_nxt    = r_last;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    if (w_grant_port == PORT_D) begin
                        // Read and write together means write.
                        w_req_nxt.read        = d_read & ~d_write;
                        w_req_nxt.write       = d_write;
                        w_req_nxt.byte_enable = d_byte_enable;
                        w_req_nxt.address     = d_address;
                        w_req_nxt.wdata       = d_wdata;
                        w_state_nxt           = BUSY_D;
                    end else begin
                        w_req_nxt.read        = 1'b1;
                        w_req_nxt.write       = 1'b0;
                        w_req_nxt.byte_enable = '1;
                        w_req_nxt.address     = i_address;
                        w_req_nxt.wdata       = '0;
                        w_state_nxt           = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp) begin
                    w_req_nxt.read  = 1'b0;
                    w_req_nxt.write = 1'b0;
                    w_last_nxt      = (r_state == BUSY_D) ? PORT_D : PORT_I;
                    w_gap_cnt_nxt   = '0;
                    w_state_nxt     = GAP;
                end
            end
            GAP: begin
                if (r_gap_cnt == 2'(GAP_CYCLES - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_req     <= '0;
            r_last    <= PORT_I;
            r_gap_cnt <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_last    <= w_last_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            if (w_i_resp) begin
                r_i_rdata <= mem_rdata;
            end
            if (w_d_resp) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_read        = r_req.read;
    assign mem_write       = r_req.write;
    assign mem_byte_enable = r_req.byte_enable;
    assign mem_address     = r_req.address;
    assign mem_wdata       = r_req.wdata;

    assign i_resp  = w_i_resp;
    assign d_resp  = w_d_resp;
    // Live memory data in the response cycle, held copy afterwards.
    assign i_rdata = w_i_resp ? mem_rdata : r_i_rdata;
    assign d_rdata = w_d_resp ? mem_rdata : r_d_rdata;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Holds a latency-20-cycle
//                memory model and a byte-level reference memory; expected
//                grant order comes from the arbitration rule (fixed priority
//                or alternate-on-tie when ARB_ROUND_ROBIN_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int DELAY_CYC = 20;  // 200 ns at 10 ns clock

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_read;
    logic [15:0] i_address;
    logic        i_resp;
    logic [15:0] i_rdata;
    logic        d_read;
    logic        d_write;
    logic [1:0]  d_byte_enable;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic        d_resp;
    logic [15:0] d_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    mem_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_read          (i_read),
        .i_address       (i_address),
        .i_resp          (i_resp),
        .i_rdata         (i_rdata),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_byte_enable   (d_byte_enable),
        .d_address       (d_address),
        .d_wdata         (d_wdata),
        .d_resp          (d_resp),
        .d_rdata         (d_rdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [15:0] mem_words [0:32767];
    logic [7:0]  ref_bytes [0:65535];
    int          n_checks = 0;
    int          n_errors = 0;
    int          mon_i    = 0;
    int          mon_d    = 0;
    bit          m_last_d = 1'b0;   // reference: last served port was D
    logic [15:0] last_d_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_word(input logic [15:0] a);
        int w;
        w = int'({a[15:1], 1'b0});
        return {ref_bytes[w + 1], ref_bytes[w]};
    endfunction

    task automatic ref_write(input logic [15:0] a, input logic [1:0] be, input logic [15:0] wd);
        int w;
        w = int'({a[15:1], 1'b0});
        if (be[0]) ref_bytes[w]     = wd[7:0];
        if (be[1]) ref_bytes[w + 1] = wd[15:8];
    endtask

    // Does D win a tie right now?
    function automatic bit pick_d();
`ifdef ARB_ROUND_ROBIN_EN
        return !m_last_d;
`else
        return 1'b1;
`endif
    endfunction

    // Memory model: fixed latency, one-cycle resp, post-write data returned.
    initial begin
        bit m_busy;
        int m_cnt;
        m_busy    = 1'b0;
        m_cnt     = 0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                m_busy   = 1'b0;
                mem_resp = 1'b0;
            end else if (mem_resp) begin
                mem_resp = 1'b0;
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    if (mem_write) begin
                        if (mem_byte_enable[0]) mem_words[mem_address[15:1]][7:0]  = mem_wdata[7:0];
                        if (mem_byte_enable[1]) mem_words[mem_address[15:1]][15:8] = mem_wdata[15:8];
                    end
                    mem_rdata = mem_words[mem_address[15:1]];
                    mem_resp  = 1'b1;
                    m_busy    = 1'b0;
                end else begin
                    m_cnt--;
                end
            end else if (mem_read || mem_write) begin
                m_busy = 1'b1;
                m_cnt  = DELAY_CYC;
            end
        end
    end

    always @(negedge clk) begin
        if (i_resp) mon_i++;
        if (d_resp) mon_d++;
    end

    // Raise the chosen requests together and run them to completion.
    task automatic run_pair(input bit do_i, input bit do_d, input bit d_wr, input bit d_rd,
                            input logic [1:0] be, input logic [15:0] ia,
                            input logic [15:0] da, input logic [15:0] wd);
        bit exp_d_first, i_done, d_done, got_first, pend_gap;
        int ci0, cd0;
        exp_d_first = do_d && (!do_i || pick_d());
        ci0 = mon_i;
        cd0 = mon_d;
        @(negedge clk);
        i_read        = do_i;
        i_address     = ia;
        d_read        = do_d && (d_rd || !d_wr);
        d_write       = do_d && d_wr;
        d_byte_enable = be;
        d_address     = da;
        d_wdata       = wd;
        @(negedge clk);
        chk("issue_addr", mem_address, exp_d_first ? da : ia);
        chk("issue_wr",   mem_write, exp_d_first && d_wr);
        chk("issue_rd",   mem_read, !(exp_d_first && d_wr));
        chk("issue_be",   mem_byte_enable, exp_d_first ? be : 2'b11);
        if (exp_d_first && d_wr) chk("issue_wdata", mem_wdata, wd);
        i_done    = !do_i;
        d_done    = !do_d;
        got_first = 1'b0;
        pend_gap  = 1'b0;
        for (int c = 0; c < 400 && !(i_done && d_done); c++) begin
            @(negedge clk);
            if (pend_gap) begin
                chk("gap_idle", {mem_read, mem_write}, 2'b00);
                pend_gap = 1'b0;
            end
            if (i_resp || d_resp) begin
                if (!got_first) chk("first_port_d", d_resp, exp_d_first);
                got_first = 1'b1;
                pend_gap  = 1'b1;
            end
            if (i_resp) begin
                chk("i_rdata", i_rdata, ref_word(ia));
                i_read = 1'b0;
                i_done = 1'b1;
            end
            if (d_resp) begin
                if (d_wr) ref_write(da, be, wd);
                chk("d_rdata", d_rdata, ref_word(da));
                last_d_rdata = d_rdata;
                d_read  = 1'b0;
                d_write = 1'b0;
                d_done  = 1'b1;
            end
        end
        chk("done", {i_done, d_done}, 2'b11);
        @(negedge clk);
        if (pend_gap) chk("gap_idle", {mem_read, mem_write}, 2'b00);
        if (do_i && do_d) m_last_d = !exp_d_first;
        else              m_last_d = do_d;
        repeat (2) @(negedge clk);
        chk("resp_cnt_i", mon_i - ci0, do_i);
        chk("resp_cnt_d", mon_d - cd0, do_d);
    endtask

    // Both ports hold read requests for n transactions.
    task automatic hold_both(input int n);
        int got, ci0, i_exp;
        bit exp_d;
        logic [15:0] ia, da;
        ia    = 16'h0300;
        da    = 16'h0400;
        ci0   = mon_i;
        i_exp = 0;
        got   = 0;
        @(negedge clk);
        i_read    = 1'b1;
        d_read    = 1'b1;
        d_write   = 1'b0;
        i_address = ia;
        d_address = da;
        for (int c = 0; c < 2000 && got < n; c++) begin
            @(negedge clk);
            if (i_resp || d_resp) begin
                exp_d    = pick_d();
                m_last_d = exp_d;
                if (!exp_d) i_exp++;
                chk("hold_port_d", d_resp, exp_d);
                chk("hold_rdata", d_resp ? d_rdata : i_rdata, ref_word(exp_d ? da : ia));
                got++;
                if (got == n) begin
                    i_read = 1'b0;
                    d_read = 1'b0;
                end
            end
        end
        chk("hold_count", got, n);
        repeat (3) @(negedge clk);
        chk("hold_i_resps", mon_i - ci0, i_exp);
    endtask

    initial begin
        logic [7:0] hi_orig;
        int cd0;
        bit seen;
        for (int k = 0; k < 32768; k++) begin
            mem_words[k]        = 16'((k * 40503) ^ 23130);
            ref_bytes[2 * k]     = mem_words[k][7:0];
            ref_bytes[2 * k + 1] = mem_words[k][15:8];
        end
        rst_n = 1'b0;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_byte_enable = '0; d_address = '0; d_wdata = '0;
        last_d_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd",   {mem_read, mem_write, mem_byte_enable}, 0);
        chk("rst_addr",  {mem_address, mem_wdata}, 0);
        chk("rst_resp",  {i_resp, d_resp}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Lone I read
        run_pair(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'h0000);

        // Partial write then read-back
        hi_orig = ref_bytes[16'h0021];
        run_pair(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 16'h0000, 16'h0020, 16'hBEEF);
        run_pair(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 16'h0000, 16'h0020, 16'h0000);
        chk("t2_lo", last_d_rdata[7:0], 8'hEF);
        chk("t2_hi", last_d_rdata[15:8], hi_orig);

        // Simultaneous requests
        run_pair(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 16'h0100, 16'h0200, 16'h0000);

        // Leave I as last served, then sustained contention
        run_pair(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0002, 16'h0000, 16'h0000);
        hold_both(4);

        // Address change while busy must not disturb the in-flight request
        @(negedge clk);
        d_read = 1'b1; d_write = 1'b0; d_address = 16'h0030;
        repeat (3) @(negedge clk);
        chk("t6_addr_pre", mem_address, 16'h0030);
        d_address = 16'h0040;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (d_resp) begin
                chk("t6_addr_resp", mem_address, 16'h0030);
                chk("t6_rdata", d_rdata, ref_word(16'h0030));
                d_read = 1'b0;
                seen   = 1'b1;
            end
        end
        chk("t6_done", seen, 1'b1);
        @(negedge clk);
        chk("t6_gap", mem_read, 1'b0);
        m_last_d = 1'b1;
        repeat (2) @(negedge clk);

        // Reset while BUSY_D
        d_read = 1'b1; d_write = 1'b0; d_address = 16'h0050;
        repeat (5) @(negedge clk);
        chk("t5_busy", mem_read, 1'b1);
        cd0 = mon_d;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_drop", {mem_read, mem_write}, 2'b00);
        chk("t5_no_resp_now", d_resp, 1'b0);
        d_read = 1'b0;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        m_last_d = 1'b0;
        repeat (30) @(negedge clk);
        chk("t5_no_dresp", mon_d - cd0, 0);
        run_pair(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0060, 16'h0000, 16'h0000);

        // Randomized mix over a small address window
        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_pair(kind != 1, kind != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 16'($urandom_range(0, 63)),
                     16'($urandom_range(0, 63)), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_mem_arbiter
`default_nettype wire
